// File: rtl/sound_out_fifo_pkg.sv
// Shared types and constants for the sound output FIFO: playback state,
// default sizing and the sample sent on an underrun.
package sound_out_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } fifo_state_t;

  localparam int DEPTH_DEF     = 8;
  localparam int LOW_WATER_DEF = 4;
  localparam logic [31:0] SILENCE = 32'h0000_0000;

endpackage

// File: rtl/sound_fifo_mem.sv
// Sample storage for the sound FIFO: circular buffer with an entry count and a
// registered read port. The caller only asserts push/pop when they are legal.
module sound_fifo_mem #(
  parameter int DEPTH = 8
) (
  input  logic                     in_clk,
  input  logic                     reset_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [31:0]              i_wr_data,
  output logic [31:0]              o_rd_data,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [31:0]   r_rd_data;
  logic [LW-1:0] r_level;

  // Storage array: contents are meaningless until written, so it has no reset.
  always_ff @(posedge in_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge in_clk) begin
    if (!reset_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_rd_data <= 32'h0000_0000;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(i_push);
      r_rd_ptr <= r_rd_ptr + AW'(i_pop);
      r_level  <= r_level + LW'(i_push) - LW'(i_pop);
      if (i_pop) begin
        r_rd_data <= r_mem[r_rd_ptr];
      end else begin
        r_rd_data <= r_rd_data;
      end
    end
  end

  assign o_rd_data = r_rd_data;
  assign o_level   = r_level;

endmodule

// File: rtl/sound_out_fifo.sv
// Playback FIFO between the NeXT sound DMA and the I2S sender: buffers samples,
// sequences IDLE/PRIME/RUN/DRAIN and reports underrun/overflow.
module sound_out_fifo
  import sound_out_fifo_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int LOW_WATER = LOW_WATER_DEF
) (
  input  logic                   in_clk,
  input  logic                   reset_n,
  input  logic                   wr_valid,
  input  logic [31:0]            wr_data,
  input  logic                   wr_end,
  input  logic                   sound_start,
  input  logic                   audio_req,
  output logic                   out_valid,
  output logic [31:0]            out_data,
  output logic                   audio_start_out,
  output logic                   fifo_req,
  output logic [$clog2(DEPTH):0] level,
  output logic                   underrun,
  output logic                   overflow
);

  localparam int LW = $clog2(DEPTH) + 1;

  fifo_state_t   r_state;
  fifo_state_t   w_state_nxt;
  logic          r_end_seen;
  logic          r_out_valid;
  logic          r_silence;
  logic          r_audio_start;
  logic          r_fifo_req;
  logic          r_underrun;
  logic          r_overflow;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_under;
  logic          w_clear;
  logic [LW-1:0] w_level_nxt;
  logic [31:0]   w_rd_data;

  // A pop frees a slot, so a write coinciding with a pop at full is accepted.
  assign w_pop   = audio_req && (r_state == ST_RUN || r_state == ST_DRAIN) && (level != LW'(0));
  assign w_under = audio_req && (r_state == ST_RUN) && (level == LW'(0));
  assign w_push  = wr_valid && ((level != LW'(DEPTH)) || w_pop);
  assign w_drop  = wr_valid && !w_push;
  assign w_clear = (r_state == ST_IDLE) && sound_start;
  assign w_level_nxt = level + LW'(w_push) - LW'(w_pop);

  sound_fifo_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .in_clk    (in_clk),
    .reset_n   (reset_n),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_wr_data (wr_data),
    .o_rd_data (w_rd_data),
    .o_level   (level)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (sound_start) w_state_nxt = ST_PRIME; else w_state_nxt = ST_IDLE;
      ST_PRIME: if (level == LW'(DEPTH) || (w_push && wr_end)) w_state_nxt = ST_RUN;
                else w_state_nxt = ST_PRIME;
      ST_RUN:   if (r_end_seen || (w_push && wr_end)) w_state_nxt = ST_DRAIN;
                else w_state_nxt = ST_RUN;
      ST_DRAIN: if (audio_req && w_level_nxt == LW'(0)) w_state_nxt = ST_IDLE;
                else w_state_nxt = ST_DRAIN;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // An end word accepted while priming still has to take RUN on to DRAIN.
  always_ff @(posedge in_clk) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_end_seen    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_silence     <= 1'b0;
      r_audio_start <= 1'b0;
      r_fifo_req    <= 1'b0;
      r_underrun    <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_out_valid   <= w_pop || w_under;
      r_audio_start <= (r_state == ST_PRIME) && (w_state_nxt == ST_RUN);
      r_fifo_req    <= (w_state_nxt == ST_PRIME || w_state_nxt == ST_RUN) &&
                       (w_level_nxt <= LW'(LOW_WATER));
      r_underrun    <= (r_underrun && !w_clear) || w_under;
      r_overflow    <= (r_overflow && !w_clear) || w_drop;
      if (w_pop || w_under) begin
        r_silence <= w_under;
      end else begin
        r_silence <= r_silence;
      end
      if (r_state == ST_IDLE) begin
        r_end_seen <= 1'b0;
      end else if (r_state == ST_PRIME && w_push && wr_end) begin
        r_end_seen <= 1'b1;
      end else begin
        r_end_seen <= r_end_seen;
      end
    end
  end

  assign out_valid       = r_out_valid;
  assign out_data        = r_silence ? SILENCE : w_rd_data;
  assign audio_start_out = r_audio_start;
  assign fifo_req        = r_fifo_req;
  assign underrun        = r_underrun;
  assign overflow        = r_overflow;

endmodule

// File: tb/tb_sound_out_fifo.sv
// Self-checking bench for sound_out_fifo: directed scenarios then random traffic,
// all compared each cycle against a queue-based playback model.
module tb_sound_out_fifo;

  localparam int DEPTH     = 8;
  localparam int LOW_WATER = 4;
  localparam int M_IDLE = 0, M_PRIME = 1, M_RUN = 2, M_DRAIN = 3;

  logic        in_clk = 1'b0;
  logic        reset_n, wr_valid, wr_end, sound_start, audio_req;
  logic [31:0] wr_data;
  logic        out_valid, audio_start_out, fifo_req, underrun, overflow;
  logic [31:0] out_data;
  logic [3:0]  level;

  int checks   = 0;
  int failures = 0;

  logic [31:0] q[$];
  int          mst = M_IDLE;
  bit          m_end, m_under, m_over, e_valid, e_start, e_req;
  logic [31:0] e_data;

  sound_out_fifo #(.DEPTH(DEPTH), .LOW_WATER(LOW_WATER)) dut (
    .in_clk(in_clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_end(wr_end), .sound_start(sound_start), .audio_req(audio_req),
    .out_valid(out_valid), .out_data(out_data), .audio_start_out(audio_start_out),
    .fifo_req(fifo_req), .level(level), .underrun(underrun), .overflow(overflow)
  );

  always #5 in_clk = ~in_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then compare every output.
  task automatic cyc(input bit rst_n, input bit wv, input logic [31:0] wd,
                     input bit we, input bit ss, input bit ar);
    int pre, nst;
    bit pop, under, push, drop, clr;
    reset_n = rst_n; wr_valid = wv; wr_data = wd; wr_end = we;
    sound_start = ss; audio_req = ar;
    if (!rst_n) begin
      q.delete(); mst = M_IDLE; m_end = 0; m_under = 0; m_over = 0;
      e_valid = 0; e_data = 32'h0; e_start = 0; e_req = 0;
    end else begin
      pre   = q.size();
      pop   = ar && (mst == M_RUN || mst == M_DRAIN) && pre > 0;
      under = ar && mst == M_RUN && pre == 0;
      push  = wv && (pre < DEPTH || pop);
      drop  = wv && !push;
      if (pop) e_data = q.pop_front();
      if (under) e_data = 32'h0;
      e_valid = pop || under;
      if (push) q.push_back(wd);
      nst = mst; clr = 0;
      case (mst)
        M_IDLE:  if (ss) begin nst = M_PRIME; clr = 1; end
        M_PRIME: if (pre == DEPTH || (push && we)) nst = M_RUN;
        M_RUN:   if (m_end || (push && we)) nst = M_DRAIN;
        default: if (ar && q.size() == 0) nst = M_IDLE;
      endcase
      if (mst == M_IDLE) m_end = 0;
      else if (mst == M_PRIME && push && we) m_end = 1;
      e_start = (mst == M_PRIME && nst == M_RUN);
      m_under = (m_under && !clr) || under;
      m_over  = (m_over && !clr) || drop;
      mst = nst;
      e_req = (mst == M_PRIME || mst == M_RUN) && q.size() <= LOW_WATER;
    end
    @(posedge in_clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    chk("out_data", out_data, e_data);
    chk("audio_start_out", 32'(audio_start_out), 32'(e_start));
    chk("fifo_req", 32'(fifo_req), 32'(e_req));
    chk("level", 32'(level), q.size());
    chk("underrun", 32'(underrun), 32'(m_under));
    chk("overflow", 32'(overflow), 32'(m_over));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_out_data", out_data, 32'h0);

    // Prime with eight words, expect the start pulse once the FIFO is full.
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) cyc(1'b1, 1'b1, 32'h0001_0001 * k, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("prime_start_pulse", 32'(audio_start_out), 32'd1);
    chk("prime_level", 32'(level), 32'd8);
    chk("prime_fifo_req", 32'(fifo_req), 32'd0);
    idle(1);
    chk("start_once", 32'(audio_start_out), 32'd0);

    // Drain eight samples in order.
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      chk("run_sample", out_data, 32'h0001_0001 * k);
      idle(1);
    end
    chk("run_fifo_req_low", 32'(fifo_req), 32'd1);

    // Underrun produces silence and sticks.
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("underrun_valid", 32'(out_valid), 32'd1);
    chk("underrun_silence", out_data, 32'h0);
    idle(3);
    chk("underrun_sticky", 32'(underrun), 32'd1);

    // Fill, overflow on the 9th, then write coincident with a pop at full.
    for (int k = 0; k < 8; k++) cyc(1'b1, 1'b1, 32'hA000_0000 + k, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    chk("overflow_set", 32'(overflow), 32'd1);
    chk("overflow_level", 32'(level), 32'd8);
    cyc(1'b1, 1'b1, 32'hB000_0008, 1'b0, 1'b0, 1'b1);
    chk("push_pop_full_level", 32'(level), 32'd8);

    // Reset mid-RUN with five entries.
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("pre_reset_level", 32'(level), 32'd5);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("mid_reset_level", 32'(level), 32'd0);
    chk("mid_reset_flags", {28'h0, out_valid, audio_start_out, underrun, overflow}, 32'h0);
    idle(1);
    chk("post_reset_quiet", {30'h0, out_valid, audio_start_out}, 32'h0);

    // Short transfer ending with wr_end, drained to IDLE.
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 32'h0000_1111, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 32'h0000_2222, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 32'h0000_3333, 1'b1, 1'b0, 1'b0);
    chk("end_start_pulse", 32'(audio_start_out), 32'd1);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      idle(1);
    end
    chk("drain_fifo_req", 32'(fifo_req), 32'd0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("idle_req_ignored", 32'(out_valid), 32'd0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 499) != 0), ($urandom_range(0, 1) == 1), $urandom,
          ($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 2) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sound_out_fifo.md
SOUND_OUT_FIFO -- requirements
Module: sound_out_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two).
REQ-002 SHALL have parameter LOW_WATER, default 4, fifo_req threshold in entries.
REQ-003 SHALL have port in_clk  input  1  sole clock, all logic on posedge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port wr_valid  input  1  NeXT-side sample word strobe.
REQ-006 SHALL have port wr_data  input  32  packed sample, L in [31:16], R in [15:0].
REQ-007 SHALL have port wr_end  input  1  qualifies wr_valid word as last of the transfer.
REQ-008 SHALL have port sound_start  input  1  one-cycle playback start request.
REQ-009 SHALL have port audio_req  input  1  one-cycle next-sample request from downstream I2S sender.
REQ-010 SHALL have port out_valid  output  1  one-cycle sample strobe to I2S sender.
REQ-011 SHALL have port out_data  output  32  sample to I2S sender, held until next out_valid.
REQ-012 SHALL have port audio_start_out  output  1  one-cycle start pulse to I2S sender.
REQ-013 SHALL have port fifo_req  output  1  level request for more words from NeXT.
REQ-014 SHALL have port level  output  $clog2(DEPTH)+1  current entry count.
REQ-015 SHALL have port underrun  output  1  sticky, audio_req served with FIFO empty.
REQ-016 SHALL have port overflow  output  1  sticky, write dropped with FIFO full.

Function
REQ-017 SHALL implement FSM states IDLE, PRIME, RUN, DRAIN.
REQ-018 IDLE: sound_start -> PRIME, clearing underrun and overflow; writes in IDLE are accepted into the FIFO.
REQ-019 PRIME: -> RUN when level==DEPTH or a wr_end word has been accepted; audio_start_out pulses exactly once, in the transition cycle.
REQ-020 RUN: accepted wr_end word -> DRAIN; DRAIN: FIFO empty and audio_req served -> IDLE.
REQ-021 Push: wr_valid with level<DEPTH stores wr_data; wr_valid with level==DEPTH drops the word and sets overflow.
REQ-022 Pop: audio_req in RUN or DRAIN with level>0 pops; out_valid and out_data asserted on the next cycle (latency 1).
REQ-023 audio_req in RUN with level==0 produces out_valid with out_data=32'h0 next cycle and sets underrun.
REQ-024 audio_req in IDLE or PRIME SHALL be ignored: no pop, no out_valid.
REQ-025 Simultaneous push and pop in one cycle SHALL both occur; level unchanged, including at level==DEPTH (pop frees the slot, push accepted).
REQ-026 Pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH or underflow below 0.
REQ-027 fifo_req SHALL be 1 when state is PRIME or RUN and level<=LOW_WATER, else 0 (registered, one-cycle lag allowed); 0 in DRAIN.
REQ-028 sound_start while not IDLE SHALL be ignored.

Reset
REQ-029 reset_n low at a clock edge SHALL force state IDLE, pointers and level 0, out_valid 0, out_data 0, audio_start_out 0, fifo_req 0, underrun 0, overflow 0.
REQ-030 Reset mid-RUN SHALL discard FIFO contents; no out_valid or audio_start_out pulse in the cycle following reset.

Structure
REQ-031 Shared package SHALL hold the FSM state typedef, DEPTH and LOW_WATER defaults, and SILENCE constant 32'h0.
REQ-032 Storage and pointers SHALL live in one sub-module sound_fifo_mem (sync write, registered read); FSM and flags in the top.

Verification
REQ-033 Reset, sound_start, write 8 words 0x00010001..0x00080008 -> audio_start_out pulse once in PRIME->RUN cycle, level 8, fifo_req 0.
REQ-034 In RUN, audio_req pulses x8 -> out_data 0x00010001..0x00080008 in order, each one cycle after its audio_req; fifo_req rises once level<=4.
REQ-035 audio_req with level 0 in RUN -> out_valid, out_data 0x00000000, underrun 1 sticky until next sound_start.
REQ-036 9th write with level 8 and no pop -> dropped, overflow 1; same write coincident with audio_req -> accepted, level stays 8.
REQ-037 Write 3 words with wr_end on 3rd from PRIME -> RUN then DRAIN, 3 samples out, IDLE after last audio_req, fifo_req 0.
REQ-038 reset_n low for one cycle mid-RUN with level 5 -> level 0, state IDLE, all outputs 0 next cycle.
